// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- single-issue ALU with a registered result stage and an optional
// iterative shift-add multiplier.
//
// One request is accepted when in_valid and in_ready are both high. Every
// opcode except MUL completes one cycle after acceptance. MUL finishes
// DATA_W+1 cycles after acceptance. The block takes no new request until the
// current one has produced its out_valid pulse.
//
// Compile-time option:
//   ALU_PIPE_MUL_EN  when defined, the MUL state and the shift-add datapath are
//                    built. When undefined, opcode 4'b1001 is illegal.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   request qualifier
//   in_ready   high only while idle; a request is accepted when both are high
//   A_bus      operand A (DATA_W)
//   B_bus      operand B (DATA_W)
//   operation  4-bit opcode
//   shift      shift amount for LSHIFT/RSHIFT/ASHR (SH_W)
//   C_bus      registered result, held between out_valid pulses
//   out_valid  one-cycle completion pulse
//   z_flag     result is zero
//   c_flag     carry (ADD/INC) or borrow (SUB/DEC), zero for other opcodes
//   n_flag     result MSB
//   err        one-cycle pulse, together with out_valid, for an illegal opcode
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int DATA_W = 16,
    parameter int SH_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] A_bus,
    input  logic [DATA_W-1:0] B_bus,
    input  logic [3:0]        operation,
    input  logic [SH_W-1:0]   shift,
    output logic [DATA_W-1:0] C_bus,
    output logic              out_valid,
    output logic              z_flag,
    output logic              c_flag,
    output logic              n_flag,
    output logic              err
);

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_INC  = 4'b0011;
    localparam logic [3:0] OP_DEC  = 4'b0100;
    localparam logic [3:0] OP_LSH  = 4'b0101;
    localparam logic [3:0] OP_RSH  = 4'b0110;
    localparam logic [3:0] OP_CLR  = 4'b0111;
    localparam logic [3:0] OP_ASHR = 4'b1000;

    localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONE_D  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W:0]   ZERO_S = {(DATA_W+1){1'b0}};
    localparam logic [DATA_W:0]   ONE_S  = {{DATA_W{1'b0}}, 1'b1};

`ifdef ALU_PIPE_MUL_EN
    localparam logic [3:0]        OP_MUL   = 4'b1001;
    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DONE = 2'b01,
        ST_MUL  = 2'b10
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DONE = 2'b01
    } state_t;
`endif

    state_t            state_r;
    state_t            state_next_s;

    logic              in_ready_r;
    logic              out_valid_r;
    logic              err_r;
    logic              z_r;
    logic              c_r;
    logic              n_r;
    logic [DATA_W-1:0] c_bus_r;

    logic              accept_s;
    logic              single_done_s;
    logic [DATA_W:0]   sum_s;
    logic [DATA_W-1:0] res_s;
    logic              carry_s;
    logic              illegal_s;

`ifdef ALU_PIPE_MUL_EN
    logic              is_mul_s;
    logic              mul_last_s;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] mcand_r;
    logic [DATA_W-1:0] mplier_r;
    logic [CNT_W-1:0]  cnt_r;

    assign is_mul_s      = (operation == OP_MUL);
    // The MUL state spends DATA_W cycles iterating and one more to publish.
    assign mul_last_s    = (state_r == ST_MUL) && (cnt_r == CNT_LAST);
    assign single_done_s = accept_s & ~is_mul_s;
`else
    assign single_done_s = accept_s;
`endif

    assign accept_s  = in_valid & in_ready_r;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign err       = err_r;
    assign C_bus     = c_bus_r;
    assign z_flag    = z_r;
    assign c_flag    = c_r;
    assign n_flag    = n_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
`ifdef ALU_PIPE_MUL_EN
                if (accept_s && is_mul_s) begin
                    state_next_s = ST_MUL;
                end else if (accept_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
`else
                if (accept_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
`endif
            end
`ifdef ALU_PIPE_MUL_EN
            ST_MUL: begin
                if (mul_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
`endif
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Single-cycle result and carry for the opcode currently on the inputs.
    always_comb begin
        sum_s     = ZERO_S;
        res_s     = ZERO_D;
        carry_s   = 1'b0;
        illegal_s = 1'b0;
        case (operation)
            OP_ADD: begin
                sum_s   = {1'b0, A_bus} + {1'b0, B_bus};
                res_s   = sum_s[DATA_W-1:0];
                carry_s = sum_s[DATA_W];
            end
            OP_SUB: begin
                // A + ~B + 1: no carry out means a borrow was needed.
                sum_s   = {1'b0, A_bus} + {1'b0, ~B_bus} + ONE_S;
                res_s   = sum_s[DATA_W-1:0];
                carry_s = ~sum_s[DATA_W];
            end
            OP_INC: begin
                sum_s   = {1'b0, A_bus} + {1'b0, B_bus} + ONE_S;
                res_s   = sum_s[DATA_W-1:0];
                carry_s = sum_s[DATA_W];
            end
            OP_DEC: begin
                // Borrow only when the full sum is zero and the result wraps.
                sum_s   = {1'b0, A_bus} + {1'b0, B_bus};
                res_s   = sum_s[DATA_W-1:0] - ONE_D;
                carry_s = (sum_s == ZERO_S);
            end
            OP_LSH:  res_s = A_bus << shift;
            OP_RSH:  res_s = A_bus >> shift;
            OP_CLR:  res_s = ZERO_D;
            OP_ASHR: res_s = $unsigned($signed(A_bus) >>> shift);
`ifdef ALU_PIPE_MUL_EN
            OP_MUL:  res_s = ZERO_D;
`endif
            default: illegal_s = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    // Shift-add multiplier: one multiplier bit per cycle, operands captured at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r    <= ZERO_D;
            mcand_r  <= ZERO_D;
            mplier_r <= ZERO_D;
            cnt_r    <= CNT_ZERO;
        end else if (accept_s && is_mul_s) begin
            acc_r    <= ZERO_D;
            mcand_r  <= A_bus;
            mplier_r <= B_bus;
            cnt_r    <= CNT_ZERO;
        end else if ((state_r == ST_MUL) && !mul_last_s) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end else begin
                acc_r <= acc_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_ONE;
        end else begin
            cnt_r    <= cnt_r;
        end
    end
`endif

    // Result, flag and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_bus_r     <= ZERO_D;
            z_r         <= 1'b0;
            c_r         <= 1'b0;
            n_r         <= 1'b0;
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
            in_ready_r  <= (state_next_s == ST_IDLE);
            if (single_done_s) begin
                out_valid_r <= 1'b1;
                c_bus_r     <= res_s;
                if (illegal_s) begin
                    // Flags keep their previous values on an illegal opcode.
                    err_r <= 1'b1;
                end else begin
                    z_r <= (res_s == ZERO_D);
                    c_r <= carry_s;
                    n_r <= res_s[DATA_W-1];
                end
            end
`ifdef ALU_PIPE_MUL_EN
            else if (mul_last_s) begin
                out_valid_r <= 1'b1;
                c_bus_r     <= acc_r;
                z_r         <= (acc_r == ZERO_D);
                c_r         <= 1'b0;
                n_r         <= acc_r[DATA_W-1];
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe -- self-checking bench for alu_pipe (DATA_W=16).
// Directed cases for the corner behaviours plus randomized operations, all
// compared against an arithmetic reference model held in the bench.
// Honours ALU_PIPE_MUL_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int DATA_W = 16;
    localparam int SH_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] A_bus;
    logic [DATA_W-1:0] B_bus;
    logic [3:0]        operation;
    logic [SH_W-1:0]   shift;
    logic [DATA_W-1:0] C_bus;
    logic              out_valid;
    logic              z_flag;
    logic              c_flag;
    logic              n_flag;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural state the model expects to see on the outputs.
    logic              m_z    = 1'b0;
    logic              m_c    = 1'b0;
    logic              m_n    = 1'b0;
    logic [DATA_W-1:0] m_cbus = 16'h0000;

    alu_pipe #(.DATA_W(DATA_W), .SH_W(SH_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A_bus     (A_bus),
        .B_bus     (B_bus),
        .operation (operation),
        .shift     (shift),
        .C_bus     (C_bus),
        .out_valid (out_valid),
        .z_flag    (z_flag),
        .c_flag    (c_flag),
        .n_flag    (n_flag),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t reached, required finish before %0t", $time, 2000000);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode definitions.
    function automatic void ref_op(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [3:0] sh,
                                   output logic [15:0] res, output logic cf,
                                   output bit ill, output int lat);
        longint ua;
        longint ub;
        longint full;
        logic [15:0] na;
        ua   = a;
        ub   = b;
        full = 0;
        res  = 16'h0000;
        cf   = 1'b0;
        ill  = 1'b0;
        lat  = 1;
        case (op)
            4'd1: begin full = ua + ub;     res = full[15:0]; cf = (full > 65535); end
            4'd2: begin full = ua - ub;     res = full[15:0]; cf = (ua < ub); end
            4'd3: begin full = ua + ub + 1; res = full[15:0]; cf = (full > 65535); end
            4'd4: begin full = ua + ub - 1; res = full[15:0]; cf = ((ua + ub) == 0); end
            4'd5: begin full = ua << sh;    res = full[15:0]; end
            4'd6: res = a >> sh;
            4'd7: res = 16'h0000;
            4'd8: begin
                // A negative value shifts right as the complement of its complement.
                na  = ~a;
                res = a[15] ? ~(na >> sh) : (a >> sh);
            end
`ifdef ALU_PIPE_MUL_EN
            4'd9: begin full = ua * ub; res = full[15:0]; lat = DATA_W + 1; end
`endif
            default: ill = 1'b1;
        endcase
    endfunction

    // Issue one request from a negedge in IDLE and check its completion.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] sh, input bit poke);
        logic [15:0] e_res;
        logic        e_c;
        bit          e_ill;
        int          e_lat;
        int          lat;
        bit          seen;
        ref_op(op, a, b, sh, e_res, e_c, e_ill, e_lat);
        check_eq("ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        A_bus     = a;
        B_bus     = b;
        operation = op;
        shift     = sh;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        A_bus     = 16'($urandom);
        B_bus     = 16'($urandom);
        operation = 4'($urandom);
        shift     = 4'($urandom);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                check_eq("busy_ready", 32'(in_ready), 32'd0);
                if (poke && lat == 3) begin
                    in_valid  = 1'b1;
                    operation = 4'd1;
                    A_bus     = 16'h1111;
                    B_bus     = 16'h2222;
                end
                if (lat == 6) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check_eq("latency", 32'(lat), 32'(e_lat));
        check_eq("c_bus", 32'(C_bus), 32'(e_res));
        check_eq("err", 32'(err), 32'(e_ill));
        if (!e_ill) begin
            m_z = (e_res == 16'h0000);
            m_c = e_c;
            m_n = e_res[15];
        end
        m_cbus = e_res;
        check_eq("z_flag", 32'(z_flag), 32'(m_z));
        check_eq("c_flag", 32'(c_flag), 32'(m_c));
        check_eq("n_flag", 32'(n_flag), 32'(m_n));
        @(negedge clk);
        check_eq("pulse_end", {30'd0, out_valid, err}, 32'd0);
        check_eq("ready_back", 32'(in_ready), 32'd1);
        check_eq("c_hold", 32'(C_bus), 32'(m_cbus));
        check_eq("flag_hold", {29'd0, z_flag, c_flag, n_flag}, {29'd0, m_z, m_c, m_n});
    endtask

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        A_bus     = 16'h0000;
        B_bus     = 16'h0000;
        operation = 4'd0;
        shift     = 4'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_c_bus", 32'(C_bus), 32'd0);
        check_eq("rst_flags", {29'd0, z_flag, c_flag, n_flag}, 32'd0);
        check_eq("rst_pulses", {30'd0, out_valid, err}, 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);

        // A request offered alongside reset is dropped.
        in_valid  = 1'b1;
        operation = 4'd1;
        A_bus     = 16'h0001;
        B_bus     = 16'h0001;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        check_eq("rst_drop_valid", 32'(out_valid), 32'd0);
        check_eq("rst_drop_c_bus", 32'(C_bus), 32'd0);

        // Directed corner cases.
        run_op(4'd1, 16'hFFFF, 16'h0001, 4'd0, 1'b0);  // ADD wrap: z=1 c=1
        run_op(4'd8, 16'h8000, 16'h0000, 4'd3, 1'b0);  // ASHR -> F000
        run_op(4'd6, 16'h8000, 16'h0000, 4'd3, 1'b0);  // RSHIFT -> 1000
        run_op(4'd5, 16'hA5A5, 16'h0000, 4'd0, 1'b0);  // shift 0 passes A
        run_op(4'd4, 16'h0000, 16'h0000, 4'd0, 1'b0);  // DEC wrap: FFFF c=1
        run_op(4'd3, 16'hFFFE, 16'h0001, 4'd0, 1'b0);  // INC carry
        run_op(4'd7, 16'h1234, 16'h5678, 4'd0, 1'b0);  // CLR
        run_op(4'd2, 16'h0003, 16'h0005, 4'd0, 1'b0);  // SUB borrow: FFFE
        run_op(4'd15, 16'h1234, 16'h5678, 4'd0, 1'b0); // illegal, flags held
        run_op(4'd0, 16'h0000, 16'h0000, 4'd0, 1'b0);  // illegal
        run_op(4'd9, 16'h0012, 16'h0034, 4'd0, 1'b1);  // MUL (or illegal)

`ifdef ALU_PIPE_MUL_EN
        // Reset in the middle of a multiply aborts it silently.
        run_op(4'd2, 16'h0003, 16'h0005, 4'd0, 1'b0);
        begin
            int pulses;
            in_valid  = 1'b1;
            operation = 4'd9;
            A_bus     = 16'h0012;
            B_bus     = 16'h0034;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            repeat (4) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_eq("mulrst_c_bus", 32'(C_bus), 32'd0);
            check_eq("mulrst_ready", 32'(in_ready), 32'd1);
            check_eq("mulrst_flags", {29'd0, z_flag, c_flag, n_flag}, 32'd0);
            pulses = 0;
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                if (out_valid) pulses++;
            end
            check_eq("mulrst_no_pulse", 32'(pulses), 32'd0);
            m_z    = 1'b0;
            m_c    = 1'b0;
            m_n    = 1'b0;
            m_cbus = 16'h0000;
        end
`endif

        // Randomized operations.
        for (int k = 0; k < 400; k++) begin
            run_op(4'($urandom_range(0, 15)), pick_val(), pick_val(),
                   4'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter DATA_W, default 16, operand/result width in bits (legal 8..32).
REQ-002 Parameter SH_W, default 4, shift-amount width; SHALL equal clog2(DATA_W).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  operation request qualifier.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 A_bus  input  DATA_W  operand A.
REQ-008 B_bus  input  DATA_W  operand B.
REQ-009 operation  input  4  opcode: 0001 ADD, 0010 SUB, 0011 INC (A+B+1), 0100 DEC (A+B-1), 0101 LSHIFT, 0110 RSHIFT, 0111 CLR, 1000 ASHR, 1001 MUL; all others illegal.
REQ-010 shift  input  SH_W  shift amount for LSHIFT/RSHIFT/ASHR.
REQ-011 C_bus  output  DATA_W  registered result.
REQ-012 out_valid  output  1  one-cycle pulse; C_bus and flags are new.
REQ-013 z_flag  output  1  result equals zero.
REQ-014 c_flag  output  1  carry out (ADD/INC), borrow (SUB/DEC); 0 for all other ops.
REQ-015 n_flag  output  1  result MSB.
REQ-016 err  output  1  one-cycle pulse with out_valid on an illegal or compiled-out opcode.

Function
REQ-017 Request accepted SHALL be exactly the cycle with in_valid=1 and in_ready=1; A_bus, B_bus, operation and shift are sampled only then.
REQ-018 FSM states IDLE, MUL, DONE; IDLE->DONE on accepted single-cycle op; IDLE->MUL on accepted MUL; MUL->DONE after DATA_W iteration cycles; DONE->IDLE unconditionally.
REQ-019 in_ready SHALL be 1 only in IDLE; a request offered while in_ready=0 is ignored, not queued.
REQ-020 Single-cycle op latency: out_valid SHALL assert exactly 1 cycle after acceptance (state DONE).
REQ-021 MUL latency: out_valid SHALL assert exactly DATA_W+1 cycles after acceptance; result is the low DATA_W bits of the unsigned A*B via shift-add, one multiplier bit per cycle.
REQ-022 Arithmetic SHALL use DATA_W+1-bit internal sums; c_flag = bit DATA_W of the sum for ADD/INC and of A+~B+1 inverted for SUB; DEC sets c_flag when A+B = 0 (wrap to all-ones).
REQ-023 RSHIFT logical, ASHR replicates A MSB, LSHIFT zero-fills; shift=0 passes A unchanged.
REQ-024 CLR SHALL drive C_bus=0, z_flag=1, c_flag=0, n_flag=0.
REQ-025 z_flag, c_flag, n_flag SHALL update on every out_valid and hold otherwise.
REQ-026 Illegal opcode SHALL complete as a single-cycle op with C_bus=0, flags unchanged, err=1.
REQ-027 C_bus SHALL hold its value between out_valid pulses.
REQ-028 Operand changes during MUL SHALL not affect the in-flight result.

Reset
REQ-029 rst=1 at a clock edge SHALL force state IDLE, C_bus=0, all flags 0, out_valid=0, err=0, in_ready=1 on the following cycle.
REQ-030 rst during MUL SHALL abort the operation with no out_valid pulse for it.
REQ-031 rst and in_valid in the same cycle: reset wins, request dropped.

Configuration
REQ-032 Macro ALU_PIPE_MUL_EN: when defined, MUL state and shift-add datapath are compiled in per REQ-021.
REQ-033 Without ALU_PIPE_MUL_EN, opcode 1001 SHALL be treated as illegal per REQ-026 and the MUL state SHALL not exist.

Verification
REQ-034 DATA_W=16: ADD A=0xFFFF B=0x0001 -> 1 cycle later out_valid, C_bus=0x0000, z=1, c=1, n=0.
REQ-035 SUB A=0x0003 B=0x0005 -> C_bus=0xFFFE, c=1 (borrow), n=1, z=0.
REQ-036 MUL A=0x0012 B=0x0034 (macro defined) -> out_valid 17 cycles after acceptance, C_bus=0x03A8; in_ready=0 throughout; second request offered mid-MUL ignored.
REQ-037 ASHR A=0x8000 shift=3 -> C_bus=0xF000, n=1; RSHIFT same operands -> 0x1000.
REQ-038 rst asserted on 5th MUL cycle -> no out_valid, C_bus=0, in_ready=1 next cycle.
REQ-039 opcode 1111 (and 1001 without macro) -> out_valid+err pulse, C_bus=0, flags unchanged.
